// File: rtl/hwpe_ycbcr2rgb_if.sv
// HWPE stream bundle: valid/ready handshake with data and byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 96
);
  logic                      valid;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     data;
  logic [DATA_WIDTH/8-1:0]   strb;

  modport master (output valid, output data, output strb, input  ready);
  modport slave  (input  valid, input  data, input  strb, output ready);
endinterface

// File: rtl/hwpe_ycbcr2rgb.sv
// Full-range BT.601 YCbCr->RGB stream converter, 2-stage elastic pipeline.
// Optional beat/clip counters enabled by defining YCBCR2RGB_STATS_EN.
module hwpe_ycbcr2rgb #(
  parameter int unsigned STREAM_WIDTH  = 96,
  parameter int unsigned CHANNEL_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  hwpe_stream_intf_stream.slave   ycbcr,
  hwpe_stream_intf_stream.master  rgb
`ifdef YCBCR2RGB_STATS_EN
  ,
  output logic [31:0]             beat_cnt_o,
  output logic [31:0]             clip_cnt_o
`endif
);
  localparam int unsigned NB_PIX = STREAM_WIDTH / 24;
  localparam int unsigned STRB_W = STREAM_WIDTH / 8;
  localparam int unsigned CW     = CHANNEL_WIDTH;
  localparam int unsigned PW     = 20;

  logic                   v1_q, v2_q, en1, en2;
  logic [NB_PIX*PW-1:0]   y_d, y_q, pr_d, pr_q, pgb_d, pgb_q, pgr_d, pgr_q, pb_d, pb_q;
  logic [STRB_W-1:0]      strb1_q, strb2_q;
  logic [STREAM_WIDTH-1:0] rgb_d, rgb_q;
  logic signed [PW-1:0]   cb_s, cr_s, r_s, g_s, b_s;
  logic [CW:0]            r_c, g_c, b_c;
`ifdef YCBCR2RGB_STATS_EN
  logic [NB_PIX-1:0]      clip_d, clip_q;
`endif

  // Returns {clamped_flag, value}; floor shift then saturate to [0,255].
  function automatic logic [CW:0] clamp8(input logic signed [PW-1:0] s);
    logic signed [PW-1:0] t;
    t = s >>> 8;
    if (t < 0)               return {1'b1, 8'h00};
    else if (t > 20'sd255)   return {1'b1, 8'hFF};
    else                     return {1'b0, t[CW-1:0]};
  endfunction

  assign en2         = ~v2_q | rgb.ready;
  assign en1         = ~v1_q | en2;
  assign ycbcr.ready = en1;
  assign rgb.valid   = v2_q;
  assign rgb.data    = rgb_q;
  assign rgb.strb    = strb2_q;

  always_comb begin
    y_d = '0; pr_d = '0; pgb_d = '0; pgr_d = '0; pb_d = '0;
    cb_s = '0; cr_s = '0;
    for (int unsigned i = 0; i < NB_PIX; i++) begin
      cb_s = PW'(ycbcr.data[24*i+CW +: CW]) - 20'sd128;
      cr_s = PW'(ycbcr.data[24*i    +: CW]) - 20'sd128;
      y_d  [PW*i +: PW] = PW'({ycbcr.data[24*i+2*CW +: CW], 8'h00});
      pr_d [PW*i +: PW] = cr_s * 20'sd359;
      pgb_d[PW*i +: PW] = cb_s * 20'sd88;
      pgr_d[PW*i +: PW] = cr_s * 20'sd183;
      pb_d [PW*i +: PW] = cb_s * 20'sd454;
    end
  end

  always_comb begin
    rgb_d = '0;
    r_s = '0; g_s = '0; b_s = '0;
    r_c = '0; g_c = '0; b_c = '0;
`ifdef YCBCR2RGB_STATS_EN
    clip_d = '0;
`endif
    for (int unsigned i = 0; i < NB_PIX; i++) begin
      r_s = $signed(y_q[PW*i +: PW]) + $signed(pr_q[PW*i +: PW]) + 20'sd128;
      g_s = $signed(y_q[PW*i +: PW]) - $signed(pgb_q[PW*i +: PW])
            - $signed(pgr_q[PW*i +: PW]) + 20'sd128;
      b_s = $signed(y_q[PW*i +: PW]) + $signed(pb_q[PW*i +: PW]) + 20'sd128;
      r_c = clamp8(r_s);
      g_c = clamp8(g_s);
      b_c = clamp8(b_s);
      rgb_d[24*i +: 24] = {r_c[CW-1:0], g_c[CW-1:0], b_c[CW-1:0]};
`ifdef YCBCR2RGB_STATS_EN
      clip_d[i] = r_c[CW] | g_c[CW] | b_c[CW];
`endif
    end
  end

  // Data registers only load with a valid beat so outputs stay 0 until the first one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; v2_q <= 1'b0;
      y_q <= '0; pr_q <= '0; pgb_q <= '0; pgr_q <= '0; pb_q <= '0;
      strb1_q <= '0; strb2_q <= '0; rgb_q <= '0;
    end else if (clear) begin
      v1_q <= 1'b0; v2_q <= 1'b0;
      y_q <= '0; pr_q <= '0; pgb_q <= '0; pgr_q <= '0; pb_q <= '0;
      strb1_q <= '0; strb2_q <= '0; rgb_q <= '0;
    end else begin
      if (en1) begin
        v1_q <= ycbcr.valid;
        if (ycbcr.valid) begin
          y_q <= y_d; pr_q <= pr_d; pgb_q <= pgb_d; pgr_q <= pgr_d; pb_q <= pb_d;
          strb1_q <= ycbcr.strb;
        end
      end
      if (en2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          rgb_q   <= rgb_d;
          strb2_q <= strb1_q;
        end
      end
    end
  end

`ifdef YCBCR2RGB_STATS_EN
  logic [31:0] beat_cnt_q, clip_cnt_q, clip_inc;
  logic [32:0] clip_sum;
  logic        hs;

  assign hs = v2_q & rgb.ready;

  always_comb begin
    clip_inc = '0;
    for (int unsigned i = 0; i < NB_PIX; i++) begin
      if (clip_q[i] && (|strb2_q[3*i +: 3])) clip_inc = clip_inc + 32'd1;
    end
    clip_sum = {1'b0, clip_cnt_q} + {1'b0, clip_inc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_q <= '0; beat_cnt_q <= '0; clip_cnt_q <= '0;
    end else if (clear) begin
      clip_q <= '0; beat_cnt_q <= '0; clip_cnt_q <= '0;
    end else begin
      if (en2 && v1_q) clip_q <= clip_d;
      if (hs) begin
        if (beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + 32'd1;
        clip_cnt_q <= clip_sum[32] ? '1 : clip_sum[31:0];
      end
    end
  end

  assign beat_cnt_o = beat_cnt_q;
  assign clip_cnt_o = clip_cnt_q;
`endif
endmodule

// File: tb/tb_hwpe_ycbcr2rgb.sv
// Self-checking bench for hwpe_ycbcr2rgb: directed table, random backpressure, clear, reset.
module tb_hwpe_ycbcr2rgb;
  localparam int unsigned SW = 96;
  localparam int unsigned NBEATS = 40;

  logic clk = 1'b0;
  logic rst_n, clear;
  int   n_cmp = 0;
  int   n_fail = 0;
  int unsigned exp_beats = 0;
  int unsigned exp_clip = 0;

  hwpe_stream_intf_stream #(.DATA_WIDTH(SW)) in_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(SW)) out_if ();

`ifdef YCBCR2RGB_STATS_EN
  logic [31:0] beat_cnt, clip_cnt;
`endif

  hwpe_ycbcr2rgb #(.STREAM_WIDTH(SW), .CHANNEL_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .ycbcr (in_if),
    .rgb   (out_if)
`ifdef YCBCR2RGB_STATS_EN
    ,
    .beat_cnt_o (beat_cnt),
    .clip_cnt_o (clip_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [23:0] pin;
    logic [23:0] pout;
    int unsigned nclip;
  } vec_t;

  typedef struct {
    logic [SW-1:0]   data;
    logic [SW/8-1:0] strb;
    int unsigned     nclip;
  } beat_t;

  beat_t sb[$];
  vec_t  vecs[4];

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  // Returns {clipped, R, G, B} for one pixel using the plain integer formulas.
  function automatic logic [24:0] ref_pix(input logic [23:0] p);
    int y, cb, cr, r, g, b, rs, gs, bs;
    logic clipped;
    y  = int'(p[23:16]);
    cb = int'(p[15:8]) - 128;
    cr = int'(p[7:0]) - 128;
    r  = (y * 256 + 359 * cr + 128) >>> 8;
    g  = (y * 256 - 88 * cb - 183 * cr + 128) >>> 8;
    b  = (y * 256 + 454 * cb + 128) >>> 8;
    clipped = (r != sat8(r)) || (g != sat8(g)) || (b != sat8(b));
    rs = sat8(r); gs = sat8(g); bs = sat8(b);
    return {clipped, rs[7:0], gs[7:0], bs[7:0]};
  endfunction

  function automatic beat_t ref_beat(input logic [SW-1:0] d, input logic [SW/8-1:0] s);
    beat_t bt;
    logic [24:0] px;
    bt.data = '0; bt.strb = s; bt.nclip = 0;
    for (int i = 0; i < SW / 24; i++) begin
      px = ref_pix(d[24*i +: 24]);
      bt.data[24*i +: 24] = px[23:0];
      if (px[24] && (|s[3*i +: 3])) bt.nclip++;
    end
    return bt;
  endfunction

  task automatic check_stats(input string tag);
`ifdef YCBCR2RGB_STATS_EN
    check({tag, "_beat_cnt"}, SW'(beat_cnt), SW'(exp_beats));
    check({tag, "_clip_cnt"}, SW'(clip_cnt), SW'(exp_clip));
`endif
  endtask

  logic [SW-1:0]   cur_d, prev_d;
  logic [SW/8-1:0] cur_s;
  logic            prev_stall;
  beat_t           bt;
  int              sent, rcvd, cyc;

  initial begin
    vecs[0] = '{pin: 24'h808080, pout: 24'h808080, nclip: 0};
    vecs[1] = '{pin: 24'hFF80FF, pout: 24'hFFA4FF, nclip: 4};
    vecs[2] = '{pin: 24'h000000, pout: 24'h008800, nclip: 4};
    vecs[3] = '{pin: 24'h4C55FF, pout: 24'hFE0000, nclip: 0};

    rst_n = 1'b0; clear = 1'b0;
    in_if.valid = 1'b0; in_if.data = '0; in_if.strb = '0; out_if.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", SW'(out_if.valid), '0);
    check("rst_data", out_if.data, '0);
    check("rst_strb", SW'(out_if.strb), '0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", SW'(in_if.ready), SW'(1));
    check_stats("rst");

    // Directed vectors: one beat each, latency exactly 2 cycles.
    out_if.ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      in_if.valid = 1'b1; in_if.data = {4{vecs[k].pin}}; in_if.strb = '1;
      #1;
      check("vec_in_ready", SW'(in_if.ready), SW'(1));
      step();
      in_if.valid = 1'b0; in_if.data = '0;
      #1;
      check("vec_valid_t1", SW'(out_if.valid), '0);
      step();
      check("vec_valid_t2", SW'(out_if.valid), SW'(1));
      check("vec_data", out_if.data, {4{vecs[k].pout}});
      check("vec_model", out_if.data, ref_beat({4{vecs[k].pin}}, '1).data);
      check("vec_strb", SW'(out_if.strb), SW'(12'hFFF));
      exp_beats++;
      exp_clip += vecs[k].nclip;
    end
    step();
    check("vec_idle", SW'(out_if.valid), '0);
    check_stats("vec");

    // Random back-to-back stream with random backpressure against the scoreboard.
    sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0; prev_d = '0;
    cur_d = {$urandom, $urandom, $urandom};
    cur_s = 12'($urandom);
    while ((sent < NBEATS || sb.size() > 0) && cyc < 2000) begin
      in_if.valid  = (sent < NBEATS);
      in_if.data   = cur_d;
      in_if.strb   = cur_s;
      out_if.ready = 1'($urandom_range(0, 1));
      #1;
      check("bp_in_ready", SW'(in_if.ready), SW'(!(sb.size() == 2 && !out_if.ready)));
      if (prev_stall) check("bp_stall_stable", out_if.data, prev_d);
      if (out_if.valid) begin
        if (sb.size() == 0) begin
          check("bp_spurious_valid", SW'(out_if.valid), '0);
        end else begin
          check("bp_data", out_if.data, sb[0].data);
          check("bp_strb", SW'(out_if.strb), SW'(sb[0].strb));
          if (out_if.ready) begin
            exp_beats++;
            exp_clip += sb[0].nclip;
            void'(sb.pop_front());
            rcvd++;
          end
        end
      end
      prev_stall = out_if.valid & ~out_if.ready;
      prev_d = out_if.data;
      if (in_if.valid && in_if.ready) begin
        sb.push_back(ref_beat(cur_d, cur_s));
        sent++;
        cur_d = {$urandom, $urandom, $urandom};
        cur_s = 12'($urandom);
      end
      cyc++;
      step();
    end
    in_if.valid = 1'b0;
    check("bp_sent", SW'(sent), SW'(NBEATS));
    check("bp_rcvd", SW'(rcvd), SW'(NBEATS));
    check_stats("bp");
    sb.delete();

    // Clear with both stages full: nothing stale may emerge.
    out_if.ready = 1'b0;
    in_if.valid = 1'b1; in_if.data = {4{24'h123456}}; in_if.strb = '1;
    step();
    in_if.data = {4{24'h654321}};
    step();
    in_if.data = {4{24'hABCDEF}};
    clear = 1'b1;
    #1;
    check("clr_in_ready_full", SW'(in_if.ready), '0);
    check("clr_valid_before", SW'(out_if.valid), SW'(1));
    step();
    clear = 1'b0; in_if.valid = 1'b0; out_if.ready = 1'b1;
    #1;
    check("clr_valid_after", SW'(out_if.valid), '0);
    check("clr_data_after", out_if.data, '0);
    exp_beats = 0; exp_clip = 0;
    check_stats("clr");
    for (int i = 0; i < 3; i++) begin
      step();
      check("clr_no_stale", SW'(out_if.valid), '0);
    end

    // Clear with one beat in S1 and a new beat offered in the same cycle.
    in_if.valid = 1'b1; in_if.data = {4{24'h808080}};
    step();
    in_if.data = {4{24'hFF80FF}};
    clear = 1'b1;
    #1;
    check("clr2_in_ready", SW'(in_if.ready), SW'(1));
    step();
    clear = 1'b0; in_if.valid = 1'b0;
    #1;
    check("clr2_valid_t1", SW'(out_if.valid), '0);
    step();
    check("clr2_valid_t2", SW'(out_if.valid), '0);

    cur_d = {$urandom, $urandom, $urandom};
    in_if.valid = 1'b1; in_if.data = cur_d; in_if.strb = '1;
    step();
    in_if.valid = 1'b0;
    #1;
    check("post_clr_t1", SW'(out_if.valid), '0);
    step();
    check("post_clr_valid", SW'(out_if.valid), SW'(1));
    check("post_clr_data", out_if.data, ref_beat(cur_d, '1).data);
    step();

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 3; i++) begin
      in_if.valid = 1'b1; in_if.data = {$urandom, $urandom, $urandom};
      step();
    end
    check("mid_valid_pre", SW'(out_if.valid), SW'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", SW'(out_if.valid), '0);
    check("mid_rst_data", out_if.data, '0);
    in_if.valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", SW'(in_if.ready), SW'(1));
    exp_beats = 0; exp_clip = 0;
    check_stats("mid");
    cur_d = {4{24'h4C55FF}};
    cur_d[23:0] = 24'($urandom);
    in_if.valid = 1'b1; in_if.data = cur_d;
    step();
    in_if.valid = 1'b0;
    step();
    check("mid_resume_valid", SW'(out_if.valid), SW'(1));
    check("mid_resume_data", out_if.data, ref_beat(cur_d, '1).data);
    step();
    check("mid_resume_idle", SW'(out_if.valid), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
